// File: rtl/pam_frame_pkg.sv
// Shared types and default constants for the PAM frame scheduler.
package pam_frame_pkg;

  localparam int unsigned ByteW = 8;

  localparam logic [ByteW-1:0] DefPreambleByte = 8'hAA;
  localparam logic [15:0]      DefSyncWord     = 16'hD391;
  localparam logic [ByteW-1:0] DefFillByte     = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSync,
    StLen,
    StPayload,
    StDrain,
    StGap
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pam_frame_scheduler.sv
// Builds preamble/sync/length/payload frames from the byte FIFO and presents them
// to the modulator through a one-entry sample register, then idles for a fixed gap.
module pam_frame_scheduler
  import pam_frame_pkg::*;
#(
  parameter int unsigned      PREAMBLE_LEN  = 4,
  parameter logic [ByteW-1:0] PREAMBLE_BYTE = DefPreambleByte,
  parameter logic [15:0]      SYNC_WORD     = DefSyncWord,
  parameter int unsigned      PAYLOAD_LEN   = 16,
  parameter logic [ByteW-1:0] FILL_BYTE     = DefFillByte,
  parameter int unsigned      GAP_CYCLES    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ByteW-1:0] data_in,
  input  logic             data_empty,
  output logic             data_read,
  output logic [ByteW-1:0] sample,
  output logic             mod_empty,
  input  logic             mod_read,
  output logic             busy,
  output logic             frame_start,
  output logic             frame_done,
  output logic             underrun
);

  localparam int unsigned CntMax = max3(PREAMBLE_LEN, PAYLOAD_LEN, GAP_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntTwo = CntW'(2);
  localparam logic [CntW-1:0] CntPre = CntW'(PREAMBLE_LEN);
  localparam logic [CntW-1:0] CntPay = CntW'(PAYLOAD_LEN);
  localparam logic [CntW-1:0] CntGap = CntW'(GAP_CYCLES);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ByteW-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             load;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sample_d      = sample_q;
    valid_d       = valid_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    data_read     = 1'b0;
    underrun      = 1'b0;
    // The sample register can take a new byte when empty or being consumed this cycle.
    load          = !valid_q || mod_read;

    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (enable && !data_empty) begin
          state_d       = StPreamble;
          cnt_d         = CntPre;
          frame_start_d = 1'b1;
        end
      end
      StPreamble: begin
        if (load) begin
          sample_d = PREAMBLE_BYTE;
          valid_d  = 1'b1;
          cnt_d    = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = StSync;
            cnt_d   = CntTwo;
          end
        end
      end
      StSync: begin
        if (load) begin
          sample_d = (cnt_q == CntTwo) ? SYNC_WORD[15:8] : SYNC_WORD[7:0];
          valid_d  = 1'b1;
          cnt_d    = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = StLen;
            cnt_d   = CntOne;
          end
        end
      end
      StLen: begin
        if (load) begin
          sample_d = ByteW'(PAYLOAD_LEN);
          valid_d  = 1'b1;
          state_d  = StPayload;
          cnt_d    = CntPay;
        end
      end
      StPayload: begin
        if (load) begin
          valid_d = 1'b1;
          if (!data_empty) begin
            sample_d  = data_in;
            data_read = 1'b1;
          end else begin
            sample_d = FILL_BYTE;
            underrun = 1'b1;
          end
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = StDrain;
            cnt_d   = '0;
          end
        end
      end
      StDrain: begin
        if (mod_read) begin
          valid_d      = 1'b0;
          frame_done_d = 1'b1;
          state_d      = StGap;
          cnt_d        = CntGap;
        end
      end
      StGap: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      sample_q      <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sample_q      <= sample_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign sample      = sample_q;
  assign mod_empty   = !valid_q;
  assign busy        = (state_q != StIdle);
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;

endmodule
